// File: rtl/mac_stream_sequencer.sv
// Streams LENGTH signed byte pairs out of the weight/data SRAMs and
// accumulates their products into a wrapping signed dot product.
module mac_stream_sequencer #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 10
) (
  input  logic              wb_clk_i,
  input  logic              i_RST_N,
  input  logic              i_START,
  input  logic              i_CLEAR,
  input  logic [ADDR_W-1:0] i_BASE_WEIGHT_ADDR,
  input  logic [ADDR_W-1:0] i_BASE_DATA_ADDR,
  input  logic [ADDR_W:0]   i_LENGTH,
  output logic              o_SELECT_WEIGHT_MEMORY,
  output logic              o_SELECT_DATA_MEMORY,
  output logic              o_WE_WEIGHT_MEMORY,
  output logic              o_WE_DATA_MEMORY,
  output logic [ADDR_W-1:0] o_WEIGHT_ADDRESS,
  output logic [ADDR_W-1:0] o_DATA_ADDRESS,
  output logic [7:0]        o_WEIGHT_INPUT,
  output logic [7:0]        o_DATA_INPUT,
  input  logic [7:0]        i_WEIGHT_OUT,
  input  logic [7:0]        i_DATA_OUT,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic [ACC_W-1:0]  o_RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;

  logic [ADDR_W:0]   len_clamped;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  assign len_clamped = (i_LENGTH > MAX_LEN) ? MAX_LEN : i_LENGTH;
  assign prod        = $signed(i_WEIGHT_OUT) * $signed(i_DATA_OUT);
  assign prod_ext    = ACC_W'(prod);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    waddr_d  = waddr_q;
    daddr_d  = daddr_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          acc_d = '0;
          if (len_clamped == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = S_FETCH;
            sel_d   = 1'b1;
            waddr_d = i_BASE_WEIGHT_ADDR;
            daddr_d = i_BASE_DATA_ADDR;
            cnt_d   = len_clamped;
            first_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // Read data lags the address by one edge, so the first FETCH edge has nothing to add.
        if (!first_q) acc_d = acc_q + prod_ext;
        first_d = 1'b0;
        if (cnt_q == (ADDR_W+1)'(1)) begin
          state_d = S_DRAIN;
          sel_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q - (ADDR_W+1)'(1);
          waddr_d = waddr_q + ADDR_W'(1);
          daddr_d = daddr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        acc_d    = acc_q + prod_ext;
        result_d = acc_q + prod_ext;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, but the last reported result survives.
    if (i_CLEAR) begin
      state_d  = S_IDLE;
      sel_d    = 1'b0;
      acc_d    = '0;
      done_d   = 1'b0;
      first_d  = 1'b0;
      result_d = result_q;
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge wb_clk_i or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      waddr_q  <= '0;
      daddr_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      waddr_q  <= waddr_d;
      daddr_q  <= daddr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign o_SELECT_WEIGHT_MEMORY = sel_q;
  assign o_SELECT_DATA_MEMORY   = sel_q;
  assign o_WE_WEIGHT_MEMORY     = 1'b0;
  assign o_WE_DATA_MEMORY       = 1'b0;
  assign o_WEIGHT_ADDRESS       = waddr_q;
  assign o_DATA_ADDRESS         = daddr_q;
  assign o_WEIGHT_INPUT         = 8'h00;
  assign o_DATA_INPUT           = 8'h00;
  assign o_BUSY                 = busy_q;
  assign o_DONE                 = done_q;
  assign o_RESULT               = result_q;

endmodule

// File: tb/tb_mac_stream_sequencer.sv
// Bench for mac_stream_sequencer: SRAM models, randomized runs, and a
// scoreboard fed by a dot-product reference model.
module tb_mac_stream_sequencer;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_START = 1'b0;
  logic              i_CLEAR = 1'b0;
  logic [ADDR_W-1:0] i_BASE_WEIGHT_ADDR = '0;
  logic [ADDR_W-1:0] i_BASE_DATA_ADDR = '0;
  logic [ADDR_W:0]   i_LENGTH = '0;
  logic              sel_w, sel_d, we_w, we_d, busy, done;
  logic [ADDR_W-1:0] waddr, daddr;
  logic [7:0]        win, din;
  logic [7:0]        w_dout = 8'h00;
  logic [7:0]        d_dout = 8'h00;
  logic [ACC_W-1:0]  result;

  logic [7:0] wmem [1024];
  logic [7:0] dmem [1024];

  logic [ACC_W-1:0]      exp_q[$];
  int                    exp_cyc_q[$];
  logic [2*ADDR_W-1:0]   addr_q[$];
  logic [ACC_W-1:0]      last_exp = '0;
  bit                    addr_chk = 1'b1;
  int                    cyc = 0;
  int                    n_checks = 0;
  int                    n_pass = 0;

  mac_stream_sequencer #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .wb_clk_i               (clk),
    .i_RST_N                (rst_n),
    .i_START                (i_START),
    .i_CLEAR                (i_CLEAR),
    .i_BASE_WEIGHT_ADDR     (i_BASE_WEIGHT_ADDR),
    .i_BASE_DATA_ADDR       (i_BASE_DATA_ADDR),
    .i_LENGTH               (i_LENGTH),
    .o_SELECT_WEIGHT_MEMORY (sel_w),
    .o_SELECT_DATA_MEMORY   (sel_d),
    .o_WE_WEIGHT_MEMORY     (we_w),
    .o_WE_DATA_MEMORY       (we_d),
    .o_WEIGHT_ADDRESS       (waddr),
    .o_DATA_ADDRESS         (daddr),
    .o_WEIGHT_INPUT         (win),
    .o_DATA_INPUT           (din),
    .i_WEIGHT_OUT           (w_dout),
    .i_DATA_OUT             (d_dout),
    .o_BUSY                 (busy),
    .o_DONE                 (done),
    .o_RESULT               (result)
  );

  // clock / reset-free free-running cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read SRAMs: address sampled at one edge, data captured at the next
  always @(posedge clk) begin
    if (sel_w) w_dout <= wmem[waddr];
    if (sel_d) d_dout <= dmem[daddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_true(input string name, input bit cond);
    chk(name, {31'd0, cond}, 32'd1);
  endtask

  // reference: plain sum of signed byte products, wrapped to ACC_W bits
  function automatic logic [ACC_W-1:0] ref_dot(input logic [ADDR_W-1:0] bw, input logic [ADDR_W-1:0] bd, input int len);
    int acc = 0;
    for (int i = 0; i < len; i++)
      acc += int'($signed(wmem[10'(bw + i)])) * int'($signed(dmem[10'(bd + i)]));
    return ACC_W'(acc);
  endfunction

  task automatic monitor();
    logic [2*ADDR_W-1:0] a;
    logic [ACC_W-1:0]    r;
    int                  c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((sel_w || sel_d) && addr_chk) begin
          chk_true("select_expected", addr_q.size() != 0);
          if (addr_q.size() != 0) begin
            a = addr_q.pop_front();
            chk("select_pair", {30'd0, sel_w, sel_d}, 32'd3);
            chk("addresses", {12'd0, waddr, daddr}, {12'd0, a});
          end
        end
        if (done) begin
          chk_true("done_expected", exp_q.size() != 0);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            chk("result", {8'd0, result}, {8'd0, r});
            chk("done_cycle", cyc, c);
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk_true("idle_wait", t < 3000);
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] bw, input logic [ADDR_W-1:0] bd,
                           input logic [ADDR_W:0] len, input int naddr, input bit expect_res);
    int L;
    logic [ACC_W-1:0] e;
    L = (len > 11'd1024) ? 1024 : int'(len);
    wait_idle();
    @(negedge clk);
    i_BASE_WEIGHT_ADDR = bw;
    i_BASE_DATA_ADDR   = bd;
    i_LENGTH           = len;
    i_START            = 1'b1;
    for (int i = 0; i < naddr; i++)
      addr_q.push_back({10'(bw + i), 10'(bd + i)});
    if (expect_res) begin
      e = ref_dot(bw, bd, L);
      exp_q.push_back(e);
      exp_cyc_q.push_back((L == 0) ? cyc + 1 : cyc + L + 2);
      last_exp = e;
    end
    @(negedge clk);
    i_START = 1'b0;
    // bases and length are latched; scrambling them must not matter
    i_BASE_WEIGHT_ADDR = 10'($urandom);
    i_BASE_DATA_ADDR   = 10'($urandom);
    i_LENGTH           = 11'($urandom);
  endtask

  task automatic wait_drained();
    int t = 0;
    while ((exp_q.size() != 0 || busy || done) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk_true("run_completes", t < 3000);
    chk("addr_queue_empty", addr_q.size(), 0);
  endtask

  task automatic run_full(input logic [ADDR_W-1:0] bw, input logic [ADDR_W-1:0] bd,
                          input logic [ADDR_W:0] len, input bit poke);
    int t = 0;
    int L;
    L = (len > 11'd1024) ? 1024 : int'(len);
    start_run(bw, bd, len, L, 1'b1);
    if (poke) begin
      while (!done && t < 3000) begin
        @(negedge clk);
        t++;
      end
      i_START = 1'b1;
      @(negedge clk);
      i_START = 1'b0;
    end
    wait_drained();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 8'($urandom);
      dmem[i] = 8'($urandom);
    end
    fork
      monitor();
    join_none

    // reset state
    #12;
    chk("rst_select", {30'd0, sel_w, sel_d}, 0);
    chk("rst_addr", {12'd0, waddr, daddr}, 0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_result", {8'd0, result}, 0);
    chk("rst_const", {14'd0, we_w, we_d, win, din}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed: small signed vector
    wmem[0] = 8'h01; wmem[1] = 8'hFE; wmem[2] = 8'h03; wmem[3] = 8'hFC;
    dmem[10'h100] = 8'h05; dmem[10'h101] = 8'h06; dmem[10'h102] = 8'hF9; dmem[10'h103] = 8'h08;
    run_full(10'h000, 10'h100, 11'd4, 1'b0);
    chk("dot4_literal", {8'd0, result}, 32'h00FFFFC4);

    // abort after four fetch cycles: no DONE, previous result kept
    start_run(10'h010, 10'h020, 11'd8, 4, 1'b0);
    repeat (3) @(negedge clk);
    chk("const_midrun", {14'd0, we_w, we_d, win, din}, 0);
    i_CLEAR = 1'b1;
    @(negedge clk);
    i_CLEAR = 1'b0;
    chk("clear_idle", {29'd0, busy, done, sel_w}, 0);
    chk("clear_keeps_result", {8'd0, result}, {8'd0, last_exp});
    repeat (12) @(negedge clk);
    chk("clear_no_done_later", {31'd0, done}, 0);

    // second start during FETCH is ignored
    start_run(10'($urandom), 10'($urandom), 11'd8, 8, 1'b1);
    repeat (2) @(negedge clk);
    i_START = 1'b1;
    @(negedge clk);
    i_START = 1'b0;
    wait_drained();

    // address wrap, zero length, start+clear together
    run_full(10'h3FE, 10'h3FF, 11'd3, 1'b1);
    run_full(10'($urandom), 10'($urandom), 11'd0, 1'b1);
    chk("zero_len_result", {8'd0, result}, 0);
    wait_idle();
    @(negedge clk);
    i_LENGTH = 11'd5;
    i_START  = 1'b1;
    i_CLEAR  = 1'b1;
    @(negedge clk);
    i_START = 1'b0;
    i_CLEAR = 1'b0;
    chk("clear_beats_start", {30'd0, busy, sel_w}, 0);

    // full-depth wrap to zero, then an over-length request clamps
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 8'h80;
      dmem[i] = 8'h80;
    end
    run_full(10'h000, 10'h000, 11'd1024, 1'b0);
    chk("full_wrap_zero", {8'd0, result}, 0);
    run_full(10'h155, 10'h2AA, 11'd1500, 1'b0);
    chk("clamped_zero", {8'd0, result}, 0);

    // randomized runs
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 8'($urandom);
      dmem[i] = 8'($urandom);
    end
    for (int r = 0; r < 14; r++)
      run_full(10'($urandom), 10'($urandom), 11'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));

    // asynchronous reset between edges during FETCH
    addr_chk = 1'b0;
    start_run(10'($urandom), 10'($urandom), 11'd8, 0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_select", {30'd0, sel_w, sel_d}, 0);
    chk("async_rst_addr", {12'd0, waddr, daddr}, 0);
    chk("async_rst_busy_done", {30'd0, busy, done}, 0);
    chk("async_rst_result", {8'd0, result}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", {30'd0, busy, done}, 0);
    addr_chk = 1'b1;
    run_full(10'($urandom), 10'($urandom), 11'd17, 1'b0);

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
